sevenseg_scan: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode/common-cathode seven-segment display. It accepts a packed set of 4-bit digit codes through a valid/ready load port and holds them in a pending register. It commits them to the display register only on frame boundaries, so a frame never shows a mix of old and new digits. Each cycle it drives one digit code on `digit_data` straight into the per-digit segment decoder (`sevenseg`), plus a one-hot digit enable with guard time against ghosting.

---
 rtl/sevenseg_scan.sv | 127 ++++++++++++
 tb/tb_sevenseg_scan.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment scan controller with frame-aligned digit commit,
// leading-zero blanking and per-slot guard time on the digit enables.
module sevenseg_scan #(
    parameter int unsigned NDIGITS  = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned GUARD    = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [4*NDIGITS-1:0]   load_digits,
    input  logic                   load_blank_lz,
    output logic [3:0]             digit_data,
    output logic [NDIGITS-1:0]     digit_en,
    output logic                   frame_done
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned SW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic                 run_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [4*NDIGITS-1:0] pend_dig_q, pend_dig_d;
    logic                 pend_blz_q, pend_blz_d;
    logic                 pend_full_q, pend_full_d;
    logic [4*NDIGITS-1:0] disp_dig_q, disp_dig_d;
    logic                 disp_blz_q, disp_blz_d;
    logic [3:0]           data_d;
    logic [NDIGITS-1:0]   en_d;
    logic                 frame_done_d;
    logic                 ready_d;
    logic                 frame_end;
    logic                 accept;
    logic                 zrun;
    logic [3:0]           code_w [NDIGITS];

    always_comb begin
        cnt_d        = cnt_q;
        slot_d       = slot_q;
        pend_dig_d   = pend_dig_q;
        pend_blz_d   = pend_blz_q;
        pend_full_d  = pend_full_q;
        disp_dig_d   = disp_dig_q;
        disp_blz_d   = disp_blz_q;
        data_d       = 4'hF;
        en_d         = '0;
        frame_done_d = 1'b0;
        zrun         = 1'b0;
        for (int unsigned i = 0; i < NDIGITS; i++) code_w[i] = 4'hF;

        frame_end = run_q && (cnt_q == CW'(PRESCALE - 1)) && (slot_q == SW'(NDIGITS - 1));
        accept    = load_valid && load_ready;

        // Counters hold the position of the current output cycle; the first
        // edge out of reset positions them at slot 0 / count 0.
        if (!run_q) begin
            cnt_d  = '0;
            slot_d = '0;
        end else if (cnt_q == CW'(PRESCALE - 1)) begin
            cnt_d  = '0;
            slot_d = (slot_q == SW'(NDIGITS - 1)) ? '0 : slot_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (frame_end && pend_full_q) begin
            disp_dig_d  = pend_dig_q;
            disp_blz_d  = pend_blz_q;
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_dig_d  = load_digits;
            pend_blz_d  = load_blank_lz;
            pend_full_d = 1'b1;
        end

        // Walk from the most significant digit down, tracking an all-zero run.
        zrun = disp_blz_d;
        for (int unsigned k = 0; k < NDIGITS; k++) begin
            code_w[NDIGITS-1-k] = disp_dig_d[4*(NDIGITS-1-k) +: 4];
            zrun = zrun && (disp_dig_d[4*(NDIGITS-1-k) +: 4] == 4'h0);
            if (zrun && (NDIGITS - 1 - k != 0)) code_w[NDIGITS-1-k] = 4'hF;
        end

        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (slot_d == SW'(i)) begin
                data_d = code_w[i];
                if (int'(cnt_d) >= int'(GUARD)) en_d[i] = 1'b1;
            end
        end

        frame_done_d = (cnt_d == CW'(PRESCALE - 1)) && (slot_d == SW'(NDIGITS - 1));
        ready_d      = !pend_full_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q       <= 1'b0;
            cnt_q       <= '0;
            slot_q      <= '0;
            pend_dig_q  <= '0;
            pend_blz_q  <= 1'b0;
            pend_full_q <= 1'b0;
            disp_dig_q  <= '1;
            disp_blz_q  <= 1'b0;
            digit_data  <= 4'hF;
            digit_en    <= '0;
            frame_done  <= 1'b0;
            load_ready  <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            pend_dig_q  <= pend_dig_d;
            pend_blz_q  <= pend_blz_d;
            pend_full_q <= pend_full_d;
            disp_dig_q  <= disp_dig_d;
            disp_blz_q  <= disp_blz_d;
            digit_data  <= data_d;
            digit_en    <= en_d;
            frame_done  <= frame_done_d;
            load_ready  <= ready_d;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with NDIGITS=4, PRESCALE=8, GUARD=2.
module tb_sevenseg_scan;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_digits;
    logic        load_blank_lz;
    logic [3:0]  digit_data;
    logic [3:0]  digit_en;
    logic        frame_done;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    sevenseg_scan #(.NDIGITS(4), .PRESCALE(8), .GUARD(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_digits   (load_digits),
        .load_blank_lz (load_blank_lz),
        .digit_data    (digit_data),
        .digit_en      (digit_en),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] digits;
        logic        blz;
        logic [15:0] exp;   // {slot3, slot2, slot1, slot0}
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step();
    endtask

    // Holds reset for three edges, checks reset outputs, then releases; cyc=0 is
    // the output cycle after the first edge with reset_n high.
    task automatic do_reset();
        reset_n       = 1'b0;
        load_valid    = 1'b0;
        load_digits   = '0;
        load_blank_lz = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("reset_outputs", {digit_en, digit_data, load_ready, frame_done}, {4'b0000, 4'hF, 1'b0, 1'b0});
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    task automatic check_frame(input string nm, input int f, input logic [15:0] exp);
        for (int s = 0; s < 4; s++) begin
            step_to(f * 32 + s * 8 + 1);
            chk({nm, "_guard"}, {digit_en, digit_data}, {4'b0000, exp[s*4 +: 4]});
            step_to(f * 32 + s * 8 + 5);
            chk({nm, "_slot"}, {digit_en, digit_data}, {4'(1 << s), exp[s*4 +: 4]});
        end
    endtask

    initial begin
        int acc;
        reset_n       = 1'b0;
        load_valid    = 1'b0;
        load_digits   = '0;
        load_blank_lz = 1'b0;

        tbl[0] = '{digits: 16'h1234, blz: 1'b0, exp: 16'h1234};
        tbl[1] = '{digits: 16'h0070, blz: 1'b1, exp: 16'hFF70};
        tbl[2] = '{digits: 16'h0000, blz: 1'b1, exp: 16'hFFF0};
        tbl[3] = '{digits: 16'h0000, blz: 1'b0, exp: 16'h0000};
        tbl[4] = '{digits: 16'h00A0, blz: 1'b1, exp: 16'hFFA0};
        tbl[5] = '{digits: 16'h0F00, blz: 1'b1, exp: 16'hFF00};

        // Idle scan after reset
        do_reset();
        for (int c = 0; c < 72; c++) begin
            int pos, sl, ct;
            logic [3:0] en;
            pos = c % 32;
            sl  = pos / 8;
            ct  = pos % 8;
            en  = (ct >= 2) ? 4'(1 << sl) : 4'b0000;
            chk("idle_scan", {digit_en, frame_done, digit_data, load_ready},
                {en, (pos == 31), 4'hF, 1'b1});
            step();
        end

        // Basic load timing
        do_reset();
        step_to(10);
        load_valid  = 1'b1;
        load_digits = 16'h1234;
        step();
        load_valid = 1'b0;
        chk("ready_low_after_accept", {31'd0, load_ready}, 32'd0);
        for (int c = 11; c < 32; c++) begin
            step_to(c);
            chk("old_data_frame1", {28'd0, digit_data}, 32'hF);
        end
        step_to(32);
        chk("ready_high_after_commit", {31'd0, load_ready}, 32'd1);
        chk("new_data_first_cycle", {28'd0, digit_data}, 32'h4);
        check_frame("basic", 1, 16'h1234);

        // Blanking table
        for (int v = 0; v < 6; v++) begin
            do_reset();
            load_valid    = 1'b1;
            load_digits   = tbl[v].digits;
            load_blank_lz = tbl[v].blz;
            step();
            load_valid = 1'b0;
            check_frame($sformatf("table%0d", v), 1, tbl[v].exp);
        end

        // Back-pressure
        do_reset();
        step_to(2);
        load_valid  = 1'b1;
        load_digits = 16'h1111;
        step();
        load_digits = 16'h2222;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            if (load_ready) begin
                acc = cyc;
                break;
            end
            step();
        end
        chk("bp_accept_cycle", 32'(acc), 32'd32);
        step();
        load_valid = 1'b0;
        check_frame("bp_frame2", 1, 16'h1111);
        check_frame("bp_frame3", 2, 16'h2222);

        // Load presented in the frame_done cycle
        do_reset();
        step_to(31);
        chk("fe_frame_done", {30'd0, frame_done, load_ready}, 32'b11);
        load_valid  = 1'b1;
        load_digits = 16'h5678;
        step();
        load_valid = 1'b0;
        chk("fe_ready_low", {31'd0, load_ready}, 32'd0);
        check_frame("fe_frame2", 1, 16'hFFFF);
        check_frame("fe_frame3", 2, 16'h5678);
        step_to(64);
        chk("fe_ready_back", {31'd0, load_ready}, 32'd1);

        // Reset mid-frame discards pending data
        do_reset();
        load_valid  = 1'b1;
        load_digits = 16'h9999;
        step();
        load_valid = 1'b0;
        step_to(20);
        reset_n = 1'b0;
        step();
        chk("midreset_outputs", {digit_en, digit_data, load_ready, frame_done}, {4'b0000, 4'hF, 1'b0, 1'b0});
        do_reset();
        chk("midreset_ready", {31'd0, load_ready}, 32'd1);
        check_frame("midreset_f1", 0, 16'hFFFF);
        check_frame("midreset_f2", 1, 16'hFFFF);
        check_frame("midreset_f3", 2, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
